// File: rtl/uart_tx_serializer_p_if.sv
// Handshake and serial-output bundle for the UART TX serializer.
// The master side (frame controller) supplies the word, the bit strobe and
// the per-word options. The slave side (serializer) returns the serial bit
// and its status flags.
interface uart_tx_serializer_p_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  BIT_TICK;
  logic                  MSB_FIRST;
  logic                  PAR_TYP;
  logic                  ser_data;
  logic                  ser_ready;
  logic                  ser_busy;
  logic                  ser_done;

  modport master (
    output P_DATA, DATA_VALID, BIT_TICK, MSB_FIRST, PAR_TYP,
    input  ser_data, ser_ready, ser_busy, ser_done
  );

  modport slave (
    input  P_DATA, DATA_VALID, BIT_TICK, MSB_FIRST, PAR_TYP,
    output ser_data, ser_ready, ser_busy, ser_done
  );
endinterface

// File: rtl/uart_tx_serializer_p.sv
// UART TX serializer: captures a DATA_WIDTH-bit word on valid/ready and
// shifts it out one bit per BIT_TICK, LSB or MSB first (chosen per word).
// Define UART_SER_PARITY_EN to append a parity bit period after the data
// bits (even parity, or odd when PAR_TYP=1 at load).
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | ready for a word; ser_data at IDLE_LEVEL
// S_SHIFT | data bits on ser_data, one per BIT_TICK
// S_PAR   | parity bit on ser_data (parity builds only)
module uart_tx_serializer_p #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  uart_tx_serializer_p_if.slave  bus
);

  localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef UART_SER_PARITY_EN
    , S_PAR = 2'd2
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  msb_q, msb_d;
  logic                  data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef UART_SER_PARITY_EN
  logic                  par_q, par_d;
`else
  logic                  unused_par_typ;
  assign unused_par_typ = bus.PAR_TYP;
`endif

  // Shifting toward the selected end always leaves the next bit at the
  // output end, so only the shift direction depends on the bit order.
  logic [DATA_WIDTH-1:0] shreg_shift;
  logic                  shift_bit;
  logic                  last_bit;

  assign shreg_shift = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
  assign shift_bit   = msb_q ? shreg_shift[DATA_WIDTH-1] : shreg_shift[0];
  assign last_bit    = (cnt_q == LAST);

  assign bus.ser_ready = (state_q == S_IDLE);
  assign bus.ser_data  = data_q;
  assign bus.ser_busy  = busy_q;
  assign bus.ser_done  = done_q;

  // State register; reset aborts any word in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.DATA_VALID) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.BIT_TICK && last_bit) begin
`ifdef UART_SER_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_SER_PARITY_EN
      S_PAR: begin
        if (bus.BIT_TICK) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs; ser_done is a pulse.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.DATA_VALID) begin
          shreg_d = bus.P_DATA;
          msb_d   = bus.MSB_FIRST;
          cnt_d   = '0;
          busy_d  = 1'b1;
          data_d  = bus.MSB_FIRST ? bus.P_DATA[DATA_WIDTH-1] : bus.P_DATA[0];
`ifdef UART_SER_PARITY_EN
          par_d   = (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
        end
      end
      S_SHIFT: begin
        if (bus.BIT_TICK) begin
          if (last_bit) begin
`ifdef UART_SER_PARITY_EN
            data_d = par_q;
`else
            data_d = IDLE_LEVEL;
            busy_d = 1'b0;
            done_d = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shreg_d = shreg_shift;
            data_d  = shift_bit;
          end
        end
      end
`ifdef UART_SER_PARITY_EN
      S_PAR: begin
        if (bus.BIT_TICK) begin
          data_d = IDLE_LEVEL;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
`endif
      default: begin
        data_d = IDLE_LEVEL;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      data_q  <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Directed bench for uart_tx_serializer_p: an 8-bit instance and a 1-bit
// instance. Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_serializer_p;

`ifdef UART_SER_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_serializer_p_if #(.DATA_WIDTH(8)) bus8 ();
  uart_tx_serializer_p_if #(.DATA_WIDTH(1)) bus1 ();

  uart_tx_serializer_p #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b0)) dut8 (
    .CLK(CLK), .RST(RST), .bus(bus8)
  );

  uart_tx_serializer_p #(.DATA_WIDTH(1), .IDLE_LEVEL(1'b0)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads a word on the 8-bit instance, then checks every cycle of every
  // bit period (exp bit i = i-th transmitted bit), then the done pulse.
  task automatic run_word(input string tag, input logic [7:0] data, input logic msb,
                          input logic ptyp, input logic [31:0] exp,
                          input int nbits, input int period);
    @(negedge CLK);
    bus8.DATA_VALID = 1'b1;
    bus8.P_DATA     = data;
    bus8.MSB_FIRST  = msb;
    bus8.PAR_TYP    = ptyp;
    @(negedge CLK);
    bus8.DATA_VALID = 1'b0;
    bus8.P_DATA     = ~data;
    bus8.MSB_FIRST  = ~msb;
    bus8.PAR_TYP    = ~ptyp;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < period; c++) begin
        if (!(i == 0 && c == 0)) @(negedge CLK);
        bus8.BIT_TICK = (c == period - 1);
        check({tag, "_bit"}, 32'(bus8.ser_data), 32'(exp[i]));
        check({tag, "_busy"}, 32'(bus8.ser_busy), 32'd1);
        check({tag, "_ready"}, 32'(bus8.ser_ready), 32'd0);
        check({tag, "_nodone"}, 32'(bus8.ser_done), 32'd0);
      end
    end
    @(negedge CLK);
    bus8.BIT_TICK = 1'b0;
    check({tag, "_done"}, 32'(bus8.ser_done), 32'd1);
    check({tag, "_idle_busy"}, 32'(bus8.ser_busy), 32'd0);
    check({tag, "_idle_data"}, 32'(bus8.ser_data), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus8.ser_ready), 32'd1);
    @(negedge CLK);
    check({tag, "_done_clr"}, 32'(bus8.ser_done), 32'd0);
  endtask

  initial begin
    bus8.P_DATA = 8'h00; bus8.DATA_VALID = 1'b0; bus8.BIT_TICK = 1'b0;
    bus8.MSB_FIRST = 1'b0; bus8.PAR_TYP = 1'b0;
    bus1.P_DATA = 1'b0; bus1.DATA_VALID = 1'b0; bus1.BIT_TICK = 1'b0;
    bus1.MSB_FIRST = 1'b0; bus1.PAR_TYP = 1'b0;

    // Reset values
    @(negedge CLK);
    check("rst_data", 32'(bus8.ser_data), 32'd0);
    check("rst_busy", 32'(bus8.ser_busy), 32'd0);
    check("rst_done", 32'(bus8.ser_done), 32'd0);
    check("rst_ready", 32'(bus8.ser_ready), 32'd1);
    check("rst_ready_w1", 32'(bus1.ser_ready), 32'd1);
    RST = 1'b1;
    @(negedge CLK);

    // Reset asserted mid-word after three ticks (A5, LSB first)
    bus8.DATA_VALID = 1'b1; bus8.P_DATA = 8'hA5; bus8.MSB_FIRST = 1'b0;
    @(negedge CLK);
    bus8.DATA_VALID = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(t == 0 && c == 0)) @(negedge CLK);
        bus8.BIT_TICK = (c == 3);
      end
    end
    @(negedge CLK);
    bus8.BIT_TICK = 1'b0;
    check("mid_bit3", 32'(bus8.ser_data), 32'd0);
    check("mid_busy", 32'(bus8.ser_busy), 32'd1);
    #1 RST = 1'b0;
    #1;
    check("abort_busy", 32'(bus8.ser_busy), 32'd0);
    check("abort_data", 32'(bus8.ser_data), 32'd0);
    check("abort_done", 32'(bus8.ser_done), 32'd0);
    check("abort_ready", 32'(bus8.ser_ready), 32'd1);
    bus8.BIT_TICK = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("abort_hold_done", 32'(bus8.ser_done), 32'd0);
      check("abort_hold_busy", 32'(bus8.ser_busy), 32'd0);
    end
    bus8.BIT_TICK = 1'b0;
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("post_rst_done", 32'(bus8.ser_done), 32'd0);
      check("post_rst_ready", 32'(bus8.ser_ready), 32'd1);
    end

    // LSB first A5: 1,0,1,0,0,1,0,1 (+ even parity 0)
    run_word("lsb_a5", 8'hA5, 1'b0, 1'b0, 32'h0A5, 8 + NPB, 4);
    // MSB first A5: bits 7..0 = 1,0,1,0,0,1,0,1 (+ parity 0)
    run_word("msb_a5", 8'hA5, 1'b1, 1'b0, 32'h0A5, 8 + NPB, 4);
    // MSB first 01: 0,0,0,0,0,0,0,1 (+ even parity 1)
    run_word("msb_01", 8'h01, 1'b1, 1'b0, (NPB == 1) ? 32'h180 : 32'h080, 8 + NPB, 4);
    // LSB first 01 with one-clock bit periods: 1,0,0,0,0,0,0,0
    run_word("lsb_01", 8'h01, 1'b0, 1'b0, (NPB == 1) ? 32'h101 : 32'h001, 8 + NPB, 1);

`ifdef UART_SER_PARITY_EN
    // 07 has three ones: even parity 1, odd parity 0
    run_word("par_even", 8'h07, 1'b0, 1'b0, 32'h107, 9, 2);
    run_word("par_odd", 8'h07, 1'b0, 1'b1, 32'h007, 9, 2);
`endif

    // Back-to-back FF then 00 with BIT_TICK tied high
    @(negedge CLK);
    bus8.DATA_VALID = 1'b1; bus8.P_DATA = 8'hFF; bus8.MSB_FIRST = 1'b0;
    bus8.PAR_TYP = 1'b0; bus8.BIT_TICK = 1'b1;
    for (int i = 0; i < 8 + NPB; i++) begin
      @(negedge CLK);
      if (i == 1) bus8.P_DATA = 8'h5A;
      check("b2b_w1_bit", 32'(bus8.ser_data), (i < 8) ? 32'd1 : 32'd0);
      check("b2b_w1_busy", 32'(bus8.ser_busy), 32'd1);
      check("b2b_w1_nodone", 32'(bus8.ser_done), 32'd0);
    end
    @(negedge CLK);
    check("b2b_done", 32'(bus8.ser_done), 32'd1);
    check("b2b_ready", 32'(bus8.ser_ready), 32'd1);
    bus8.P_DATA = 8'h00;
    for (int i = 0; i < 8 + NPB; i++) begin
      @(negedge CLK);
      if (i == 0) bus8.DATA_VALID = 1'b0;
      if (i == 2) bus8.P_DATA = 8'hFF;
      check("b2b_w2_bit", 32'(bus8.ser_data), 32'd0);
      check("b2b_w2_busy", 32'(bus8.ser_busy), 32'd1);
    end
    @(negedge CLK);
    bus8.BIT_TICK = 1'b0;
    check("b2b_w2_done", 32'(bus8.ser_done), 32'd1);
    check("b2b_w2_idle", 32'(bus8.ser_busy), 32'd0);
    @(negedge CLK);
    check("b2b_done_clr", 32'(bus8.ser_done), 32'd0);

    // DATA_WIDTH=1: ticks while idle change nothing
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      bus1.BIT_TICK = k[0];
      check("w1_idle_data", 32'(bus1.ser_data), 32'd0);
      check("w1_idle_busy", 32'(bus1.ser_busy), 32'd0);
      check("w1_idle_done", 32'(bus1.ser_done), 32'd0);
    end
    @(negedge CLK);
    bus1.BIT_TICK = 1'b0; bus1.DATA_VALID = 1'b1; bus1.P_DATA = 1'b1;
    @(negedge CLK);
    bus1.DATA_VALID = 1'b0; bus1.P_DATA = 1'b0;
    // one data bit of 1, then (parity builds) even parity of 1 = 1
    for (int i = 0; i < 1 + NPB; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(i == 0 && c == 0)) @(negedge CLK);
        bus1.BIT_TICK = (c == 1);
        check("w1_bit", 32'(bus1.ser_data), 32'd1);
        check("w1_busy", 32'(bus1.ser_busy), 32'd1);
        check("w1_nodone", 32'(bus1.ser_done), 32'd0);
      end
    end
    @(negedge CLK);
    bus1.BIT_TICK = 1'b0;
    check("w1_done", 32'(bus1.ser_done), 32'd1);
    check("w1_end_data", 32'(bus1.ser_data), 32'd0);
    check("w1_end_busy", 32'(bus1.ser_busy), 32'd0);
    @(negedge CLK);
    check("w1_done_clr", 32'(bus1.ser_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
